// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: md_op encodings and FSM states.
package md_pkg;

  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MFHI  = 4'd5;
  localparam logic [3:0] MD_MFLO  = 4'd6;
  localparam logic [3:0] MD_MTHI  = 4'd7;
  localparam logic [3:0] MD_MTLO  = 4'd8;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  function automatic logic is_arith(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_calc.sv
// Combinational HI/LO result generator for mult/multu/div/divu, including
// signed-overflow and divide-by-zero handling.
module md_calc
  import md_pkg::*;
(
  input  logic [3:0]  i_md_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_hi_res,
  output logic [31:0] o_lo_res,
  output logic        o_div_zero
);

  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;
  logic        w_ovf;
  logic        w_bzero;
  logic [31:0] w_bdiv;
  logic [31:0] w_quo_s;
  logic [31:0] w_rem_s;
  logic [31:0] w_quo_u;
  logic [31:0] w_rem_u;

  assign w_prod_s = $signed({{32{i_a[31]}}, i_a}) * $signed({{32{i_b[31]}}, i_b});
  assign w_prod_u = {32'd0, i_a} * {32'd0, i_b};

  assign w_bzero  = (i_b == '0);
  assign w_ovf    = (i_a == 32'h8000_0000) && (i_b == 32'hFFFF_FFFF);
  // Divisor forced to 1 for the two special cases so the dividers never see them.
  assign w_bdiv   = (w_bzero || w_ovf) ? 32'd1 : i_b;

  assign w_quo_s  = $signed(i_a) / $signed(w_bdiv);
  assign w_rem_s  = $signed(i_a) % $signed(w_bdiv);
  assign w_quo_u  = i_a / w_bdiv;
  assign w_rem_u  = i_a % w_bdiv;

  always_comb begin
    o_hi_res   = '0;
    o_lo_res   = '0;
    o_div_zero = 1'b0;
    case (i_md_op)
      MD_MULT:  {o_hi_res, o_lo_res} = w_prod_s;
      MD_MULTU: {o_hi_res, o_lo_res} = w_prod_u;
      MD_DIV: begin
        o_div_zero = w_bzero;
        if (w_ovf) begin
          o_hi_res = '0;
          o_lo_res = 32'h8000_0000;
        end else begin
          o_hi_res = w_rem_s;
          o_lo_res = w_quo_s;
        end
      end
      MD_DIVU: begin
        o_div_zero = w_bzero;
        o_hi_res   = w_rem_u;
        o_lo_res   = w_quo_u;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// E-stage multiply/divide unit: owns HI/LO, models fixed latency with a busy
// handshake, and handles MTHI/MTLO/MFHI/MFLO.
module md_unit
  import md_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  md_op,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] md_out
);

  localparam int unsigned MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW   = $clog2(MAXC + 1);

  md_state_e   r_state;
  logic [CW-1:0] r_cnt;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_hi_tmp;
  logic [31:0] r_lo_tmp;
  logic        r_dz;

  logic [31:0] w_hi_res;
  logic [31:0] w_lo_res;
  logic        w_div_zero;
  logic        w_is_mul;
  logic [CW-1:0] w_lat;

  md_calc u_calc (
    .i_md_op    (md_op),
    .i_a        (A),
    .i_b        (B),
    .o_hi_res   (w_hi_res),
    .o_lo_res   (w_lo_res),
    .o_div_zero (w_div_zero)
  );

  assign w_is_mul = (md_op == MD_MULT) || (md_op == MD_MULTU);
  assign w_lat    = w_is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);

  // The start cycle itself is the first busy cycle, so RUN lasts N-1 cycles and
  // the counter is loaded with N-1; N==1 commits straight from IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_hi_tmp <= '0;
      r_lo_tmp <= '0;
      r_dz     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start && is_arith(md_op)) begin
            r_hi_tmp <= w_hi_res;
            r_lo_tmp <= w_lo_res;
            r_dz     <= w_div_zero;
            if (w_lat == CW'(1)) begin
              if (!w_div_zero) begin
                r_hi <= w_hi_res;
                r_lo <= w_lo_res;
              end
            end else begin
              r_cnt   <= w_lat - CW'(1);
              r_state <= ST_RUN;
            end
          end else if (!start && md_op == MD_MTHI) begin
            r_hi <= A;
          end else if (!start && md_op == MD_MTLO) begin
            r_lo <= A;
          end
        end
        ST_RUN: begin
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_state <= ST_IDLE;
            if (!r_dz) begin
              r_hi <= r_hi_tmp;
              r_lo <= r_lo_tmp;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy   = start | (r_state == ST_RUN);
  assign hi     = r_hi;
  assign lo     = r_lo;
  assign md_out = (md_op == MD_MFHI) ? r_hi :
                  (md_op == MD_MFLO) ? r_lo : '0;

endmodule

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit with hand-computed HI/LO results.
module tb_md_unit;
  import md_pkg::*;

  localparam int unsigned MC = 5;
  localparam int unsigned DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  md_op;
  logic        start;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] md_out;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk    (clk),
    .reset  (reset),
    .md_op  (md_op),
    .start  (start),
    .A      (A),
    .B      (B),
    .busy   (busy),
    .hi     (hi),
    .lo     (lo),
    .md_out (md_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Launch an op in the current cycle; check busy through the run with the old
  // hi/lo held and operands scrambled, then check busy drop and the new values.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int unsigned n, input logic stray_start,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    logic [31:0] old_hi;
    logic [31:0] old_lo;
    old_hi = hi;
    old_lo = lo;
    md_op = op; A = a; B = b; start = 1'b1;
    #1;
    chk({tag, "_busy0"}, 32'(busy), 32'd1);
    for (int unsigned i = 1; i < n; i++) begin
      next_cycle();
      start = 1'b0;
      A = 32'h5A5A_0000 + i;
      B = 32'h0000_0003 + i;
      if (stray_start && i == 2) begin
        md_op = MD_MULTU;
        start = 1'b1;
      end else begin
        md_op = MD_NONE;
      end
      #1;
      chk({tag, "_busyrun"}, 32'(busy), 32'd1);
      chk({tag, "_hihold"}, hi, old_hi);
      chk({tag, "_lohold"}, lo, old_lo);
    end
    next_cycle();
    start = 1'b0;
    md_op = MD_NONE;
    #1;
    chk({tag, "_busyN"}, 32'(busy), 32'd0);
    chk({tag, "_hi"}, hi, exp_hi);
    chk({tag, "_lo"}, lo, exp_lo);
  endtask

  initial begin
    reset = 1'b1; md_op = MD_NONE; start = 1'b0; A = '0; B = '0;
    next_cycle();
    next_cycle();
    reset = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_mdout", md_out, 32'd0);

    next_cycle();
    run_op("mult", MD_MULT, 32'hFFFF_FFFE, 32'd3, MC, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op("multu", MD_MULTU, 32'hFFFF_FFFF, 32'd2, MC, 1'b0, 32'h0000_0001, 32'hFFFF_FFFE);
    run_op("div", MD_DIV, 32'hFFFF_FFF9, 32'd2, DC, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, DC, 1'b0, 32'h0, 32'h8000_0000);
    run_op("divu0", MD_DIVU, 32'd5, 32'd0, DC, 1'b0, 32'h0, 32'h8000_0000);

    // Start with a non-arithmetic op is ignored.
    md_op = MD_MFHI; start = 1'b1; A = 32'hDEAD_BEEF;
    next_cycle();
    start = 1'b0; md_op = MD_NONE;
    #1;
    chk("nonarith_busy", 32'(busy), 32'd0);
    chk("nonarith_hi", hi, 32'h0);

    md_op = MD_MTHI; A = 32'h1234_5678;
    next_cycle();
    md_op = MD_MFHI;
    #1;
    chk("mthi_hi", hi, 32'h1234_5678);
    chk("mfhi_out", md_out, 32'h1234_5678);
    md_op = MD_MFLO;
    #1;
    chk("mflo_out", md_out, 32'h8000_0000);
    md_op = MD_NONE;
    #1;
    chk("none_out", md_out, 32'h0);

    // MTLO while busy must not touch lo.
    md_op = MD_DIVU; A = 32'd100; B = 32'd7; start = 1'b1;
    next_cycle();
    start = 1'b0; md_op = MD_MTLO; A = 32'hCAFE_F00D;
    next_cycle();
    chk("mtlo_busy_lo", lo, 32'h8000_0000);
    chk("mtlo_busy_out", md_out, 32'h0);
    md_op = MD_NONE;
    for (int unsigned i = 2; i < DC; i++) next_cycle();
    chk("divu_busy", 32'(busy), 32'd0);
    chk("divu_hi", hi, 32'd2);
    chk("divu_lo", lo, 32'd14);

    // Reset in cycle 4 of a DIV aborts it.
    md_op = MD_DIV; A = 32'd1000; B = 32'd3; start = 1'b1;
    next_cycle();
    start = 1'b0; md_op = MD_NONE;
    next_cycle();
    next_cycle();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_hi", hi, 32'h0);
    chk("abort_lo", lo, 32'h0);
    for (int unsigned i = 0; i < DC; i++) next_cycle();
    chk("abort_late_busy", 32'(busy), 32'd0);
    chk("abort_late_hi", hi, 32'h0);
    chk("abort_late_lo", lo, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
